// File: rtl/wb_ctrl_pipe.sv
// Write-control pipeline for the RV32I core: decodes register-file/data-memory write enables,
// carries them with rd through STAGES registers, and exposes a RAW scoreboard.
module wb_ctrl_pipe #(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned MEM_STAGE = 1,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned CNT_W     = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [XLEN-1:0] instruction,
  input  logic            stall,
  input  logic            flush,
  input  logic [RA_W-1:0] rs1_q,
  input  logic [RA_W-1:0] rs2_q,
  output logic            illegal,
  output logic            mem_we,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic            hazard_rs1,
  output logic            hazard_rs2,
  output logic [CNT_W-1:0] inflight_wr
);

  localparam int unsigned Last = STAGES - 1;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [STAGES-1:0]           valid_q, valid_d;
  logic [STAGES-1:0]           wr_q, wr_d;
  logic [STAGES-1:0]           wm_q, wm_d;
  logic [STAGES-1:0][RA_W-1:0] rd_q, rd_d;

  logic [6:0]      opcode;
  logic [RA_W-1:0] dec_rd;
  logic            dec_wr, dec_wm, dec_ill;

  always_comb begin
    opcode  = instruction[6:0];
    dec_rd  = RA_W'(instruction[11:7]);
    dec_wr  = 1'b0;
    dec_wm  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OpLoad, OpImm, OpAuipc, OpLui, OpReg, OpJal, OpJalr: dec_wr = 1'b1;
      OpStore:                                            dec_wm = 1'b1;
      OpBranch, OpSystem:                                 ;
      default:                                            dec_ill = 1'b1;
    endcase
    // x0 is hardwired; a write to it is not a real write
    if (dec_rd == '0) dec_wr = 1'b0;
  end

  assign illegal = valid_in & dec_ill;

  // Flush empties every stage: the writeback entry commits this cycle and then leaves.
  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    wm_d    = wm_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = '0;
      wr_d    = '0;
      wm_d    = '0;
      rd_d    = '0;
    end else if (!stall) begin
      valid_d = {valid_q[STAGES-2:0], valid_in};
      wr_d    = {wr_q[STAGES-2:0], valid_in & dec_wr};
      wm_d    = {wm_q[STAGES-2:0], valid_in & dec_wm};
      rd_d    = {rd_q[STAGES-2:0], dec_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_q    <= '0;
      wm_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      wm_q    <= wm_d;
      rd_q    <= rd_d;
    end
  end

  assign mem_we = valid_q[MEM_STAGE] & wm_q[MEM_STAGE] & ~stall & ~flush;
  assign wb_we  = valid_q[Last] & wr_q[Last] & (~stall | flush);
  assign wb_rd  = valid_q[Last] ? rd_q[Last] : '0;

  always_comb begin
    hazard_rs1  = 1'b0;
    hazard_rs2  = 1'b0;
    inflight_wr = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (valid_q[i] && wr_q[i]) begin
        inflight_wr = inflight_wr + CNT_W'(1);
        if (rd_q[i] == rs1_q) hazard_rs1 = 1'b1;
        if (rd_q[i] == rs2_q) hazard_rs2 = 1'b1;
      end
    end
    if (rs1_q == '0) hazard_rs1 = 1'b0;
    if (rs2_q == '0) hazard_rs2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed + random bench for wb_ctrl_pipe; expected values come from a queue of in-flight
// instructions tagged with their age, advanced by the stall/flush rules.
module tb_wb_ctrl_pipe;

  localparam int STAGES    = 3;
  localparam int MEM_STAGE = 1;
  localparam int CNT_W     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [31:0]      instruction = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [4:0]       rs1_q = '0;
  logic [4:0]       rs2_q = '0;
  logic             illegal, mem_we, wb_we, hazard_rs1, hazard_rs2;
  logic [4:0]       wb_rd;
  logic [CNT_W-1:0] inflight_wr;

  wb_ctrl_pipe #(
    .STAGES   (STAGES),
    .MEM_STAGE(MEM_STAGE),
    .XLEN     (32),
    .RA_W     (5),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .instruction(instruction),
    .stall      (stall),
    .flush      (flush),
    .rs1_q      (rs1_q),
    .rs2_q      (rs2_q),
    .illegal    (illegal),
    .mem_we     (mem_we),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .hazard_rs1 (hazard_rs1),
    .hazard_rs2 (hazard_rs2),
    .inflight_wr(inflight_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    bit         wr;
    bit         wm;
    int         age;
  } rec_t;

  rec_t pipe[$];
  int   wb_log[$];
  int   wb_cyc[$];
  int   mem_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   peak = 0;
  int   c0;

  function automatic bit is_write_op(logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h17, 7'h37, 7'h33, 7'h6f, 7'h67};
  endfunction

  function automatic bit is_known(logic [6:0] op);
    return is_write_op(op) || (op inside {7'h23, 7'h63, 7'h73});
  endfunction

  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd);
    return {20'h00100, rd, op};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic check_outputs();
    logic       ewb = 1'b0, emem = 1'b0, eh1 = 1'b0, eh2 = 1'b0, eill;
    logic [4:0] erd = '0;
    int         ecnt = 0;
    eill = valid_in && !is_known(instruction[6:0]);
    foreach (pipe[i]) begin
      if (pipe[i].age == STAGES - 1) begin
        erd = pipe[i].rd;
        if (pipe[i].wr && (!stall || flush)) ewb = 1'b1;
      end
      if (pipe[i].age == MEM_STAGE && pipe[i].wm && !stall && !flush) emem = 1'b1;
      if (pipe[i].wr) begin
        ecnt++;
        if (rs1_q != 0 && pipe[i].rd == rs1_q) eh1 = 1'b1;
        if (rs2_q != 0 && pipe[i].rd == rs2_q) eh2 = 1'b1;
      end
    end
    chk("illegal", illegal, eill);
    chk("mem_we", mem_we, emem);
    chk("wb_we", wb_we, ewb);
    chk("wb_rd", wb_rd, erd);
    chk("hazard_rs1", hazard_rs1, eh1);
    chk("hazard_rs2", hazard_rs2, eh2);
    chk("inflight_wr", inflight_wr, ecnt);
  endtask

  task automatic model_edge();
    rec_t nq[$];
    rec_t r;
    if (!rst_n || flush) begin
      pipe.delete();
    end else if (!stall) begin
      foreach (pipe[i]) begin
        r = pipe[i];
        r.age++;
        if (r.age < STAGES) nq.push_back(r);
      end
      if (valid_in) begin
        r.rd  = instruction[11:7];
        r.wr  = is_write_op(instruction[6:0]) && (instruction[11:7] != 0);
        r.wm  = (instruction[6:0] == 7'h23);
        r.age = 0;
        nq.push_back(r);
      end
      pipe = nq;
    end
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model on the edge.
  task automatic cyc(bit v, logic [31:0] ins, bit st, bit fl);
    valid_in    = v;
    instruction = ins;
    stall       = st;
    flush       = fl;
    @(negedge clk);
    check_outputs();
    if (wb_we === 1'b1) begin
      wb_log.push_back(int'(wb_rd));
      wb_cyc.push_back(cyc_n);
    end
    if (mem_we === 1'b1) mem_cyc.push_back(cyc_n);
    if (int'(inflight_wr) > peak) peak = int'(inflight_wr);
    @(posedge clk);
    model_edge();
    #1;
    cyc_n++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_logs();
    wb_log.delete();
    wb_cyc.delete();
    mem_cyc.delete();
    peak = 0;
  endtask

  logic [6:0] ops[12];
  logic [31:0] rnd;

  initial begin
    ops = '{7'h03, 7'h13, 7'h17, 7'h37, 7'h33, 7'h6f, 7'h67, 7'h23, 7'h63, 7'h73, 7'h7f, 7'h0b};

    // Reset
    idle(2);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_inflight", inflight_wr, 0);
    rst_n = 1'b1;
    idle(1);

    // addi x5,x0,1
    clear_logs();
    rs1_q = 5'd5;
    c0 = cyc_n;
    cyc(1'b1, 32'h00100293, 1'b0, 1'b0);
    chk("addi_haz", hazard_rs1, 1);
    chk("addi_cnt1", inflight_wr, 1);
    idle(4);
    chk("addi_nwb", wb_log.size(), 1);
    if (wb_log.size() == 1) begin
      chk("addi_rd", wb_log[0], 5);
      chk("addi_lat", wb_cyc[0] - c0, STAGES);
    end

    // sw
    clear_logs();
    c0 = cyc_n;
    cyc(1'b1, 32'h00502023, 1'b0, 1'b0);
    idle(4);
    chk("sw_nmem", mem_cyc.size(), 1);
    if (mem_cyc.size() == 1) chk("sw_lat", mem_cyc[0] - c0, MEM_STAGE + 1);
    chk("sw_nwb", wb_log.size(), 0);

    // add x0, beq, jal x1, illegal
    clear_logs();
    cyc(1'b1, 32'h00000033, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000063, 1'b0, 1'b0);
    cyc(1'b1, 32'h000000ef, 1'b0, 1'b0);
    valid_in = 1'b1;
    instruction = 32'h0000007f;
    #1;
    chk("illegal_in", illegal, 1);
    cyc(1'b1, 32'h0000007f, 1'b0, 1'b0);
    idle(4);
    chk("mix_nwb", wb_log.size(), 1);
    if (wb_log.size() == 1) chk("jal_rd", wb_log[0], 1);
    chk("mix_nmem", mem_cyc.size(), 0);

    // Back-to-back writes with a 2-cycle stall after the second
    clear_logs();
    c0 = cyc_n;
    cyc(1'b1, mk(7'h13, 5'd5), 1'b0, 1'b0);
    cyc(1'b1, mk(7'h13, 5'd6), 1'b0, 1'b0);
    cyc(1'b1, mk(7'h13, 5'd7), 1'b1, 1'b0);
    cyc(1'b1, mk(7'h13, 5'd7), 1'b1, 1'b0);
    cyc(1'b1, mk(7'h13, 5'd7), 1'b0, 1'b0);
    idle(5);
    chk("stall_nwb", wb_log.size(), 3);
    if (wb_log.size() == 3) begin
      chk("stall_rd0", wb_log[0], 5);
      chk("stall_rd1", wb_log[1], 6);
      chk("stall_rd2", wb_log[2], 7);
      chk("stall_lat", wb_cyc[0] - c0, STAGES + 2);
    end
    chk("stall_peak", peak, 3);

    // Flush, then flush with stall
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      cyc(1'b1, mk(7'h13, 5'd5), 1'b0, 1'b0);
      cyc(1'b1, mk(7'h13, 5'd6), 1'b0, 1'b0);
      cyc(1'b1, mk(7'h13, 5'd7), 1'b0, 1'b0);
      cyc(1'b1, mk(7'h13, 5'd9), k[0], 1'b1);
      chk("flush_cnt0", inflight_wr, 0);
      idle(4);
      chk("flush_nwb", wb_log.size(), 1);
      if (wb_log.size() == 1) chk("flush_rd", wb_log[0], 5);
    end

    // Asynchronous reset between edges
    clear_logs();
    cyc(1'b1, mk(7'h13, 5'd5), 1'b0, 1'b0);
    cyc(1'b1, mk(7'h13, 5'd6), 1'b0, 1'b0);
    valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_haz", hazard_rs1, 0);
    chk("arst_cnt", inflight_wr, 0);
    chk("arst_rd", wb_rd, 0);
    pipe.delete();
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(4);
    chk("arst_nwb", wb_log.size(), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      rnd[11:7] = 5'($urandom_range(0, 7));
      rnd[6:0]  = ops[$urandom_range(0, 11)];
      rs1_q = 5'($urandom_range(0, 7));
      rs2_q = 5'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 11) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
